calendar_date_counter: RTL and testbench

// Sequential date source for the Calendar design. Holds the current date
// (dayOfMonth, month, year) and advances it on a day tick, on a software load,
// or via a multi-day fast-forward. Outputs feed dayOfYrCalc directly, with the

---
 rtl/calendar_date_counter.sv | 145 ++++++++++++++
 tb/tb_calendar_date_counter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calendar_date_counter.sv
// Calendar date source: day tick, validated load and multi-day fast-forward.
// Gregorian or Symmetry454 month lengths selected by cal_select.
module calendar_date_counter #(
  parameter bit          cal_select = 1'b0,
  parameter logic [10:0] RESET_YEAR = 11'd2018
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        day_tick,
  input  logic        load,
  input  logic [5:0]  ld_day,
  input  logic [3:0]  ld_month,
  input  logic [10:0] ld_year,
  input  logic        adv_req,
  input  logic [8:0]  adv_count,
  output logic [5:0]  dayOfMonth,
  output logic [3:0]  month,
  output logic [10:0] year,
  output logic        date_upd,
  output logic        year_wrap,
  output logic        load_err,
  output logic        busy
);

  typedef enum logic {IDLE, ADVANCE} state_t;

  state_t     state;
  logic [8:0] rem;

  function automatic logic [5:0] mlen(
    input logic [3:0] m,
    input logic       leap
  );
    logic [5:0] l;
    l = 6'd31;
    if (cal_select) begin
      if (m == 4'd2 || m == 4'd5 ||
          m == 4'd8 || m == 4'd11)
        l = 6'd35;
      else
        l = 6'd28;
    end else begin
      case (m)
        4'd2:    l = leap ? 6'd29 : 6'd28;
        4'd4,
        4'd6,
        4'd9,
        4'd11:   l = 6'd30;
        default: l = 6'd31;
      endcase
    end
    return l;
  endfunction

  logic [5:0]  cur_len;
  logic        last_day;
  logic        last_mon;
  logic [5:0]  nxt_day;
  logic [3:0]  nxt_mon;
  logic [10:0] nxt_yr;
  logic        nxt_wrap;
  logic [5:0]  ld_len;
  logic        ld_ok;
  logic [8:0]  rem_sat;
  logic [8:0]  rem_nxt;

  always_comb begin
    cur_len  = mlen(month, year[1:0] == 2'b00);
    last_day = dayOfMonth >= cur_len;
    last_mon = month == 4'd12;
    nxt_day  = last_day ? 6'd1 : dayOfMonth + 6'd1;
    nxt_mon  = month;
    if (last_day)
      nxt_mon = last_mon ? 4'd1 : month + 4'd1;
    // 2047 + 1 wraps to 0 in the 11-bit add
    nxt_yr   = (last_day && last_mon) ? year + 11'd1 : year;
    nxt_wrap = last_day && last_mon && year == 11'd2047;
    ld_len   = mlen(ld_month, ld_year[1:0] == 2'b00);
    ld_ok    = ld_month >= 4'd1 && ld_month <= 4'd12 &&
               ld_day >= 6'd1 && ld_day <= ld_len;
    // a tick during fast-forward extends the run instead of being dropped
    rem_sat  = (day_tick && rem != 9'h1FF) ? rem + 9'd1 : rem;
    rem_nxt  = rem_sat - 9'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rem        <= 9'd0;
      dayOfMonth <= 6'd1;
      month      <= 4'd1;
      year       <= RESET_YEAR;
      date_upd   <= 1'b0;
      year_wrap  <= 1'b0;
      load_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      date_upd  <= 1'b0;
      year_wrap <= 1'b0;
      load_err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load) begin
            if (ld_ok) begin
              dayOfMonth <= ld_day;
              month      <= ld_month;
              year       <= ld_year;
              date_upd   <= 1'b1;
            end else begin
              load_err <= 1'b1;
            end
          end else if (day_tick) begin
            dayOfMonth <= nxt_day;
            month      <= nxt_mon;
            year       <= nxt_yr;
            year_wrap  <= nxt_wrap;
            date_upd   <= 1'b1;
          end else if (adv_req && adv_count != 9'd0) begin
            rem   <= adv_count;
            state <= ADVANCE;
            busy  <= 1'b1;
          end
        end
        ADVANCE: begin
          dayOfMonth <= nxt_day;
          month      <= nxt_mon;
          year       <= nxt_yr;
          year_wrap  <= nxt_wrap;
          date_upd   <= 1'b1;
          load_err   <= load;
          rem        <= rem_nxt;
          if (rem_nxt == 9'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calendar_date_counter.sv
// Bench for calendar_date_counter: both calendars against a date model,
// directed corner cases followed by random traffic.
module tb_calendar_date_counter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        day_tick;
  logic        load;
  logic [5:0]  ld_day;
  logic [3:0]  ld_month;
  logic [10:0] ld_year;
  logic        adv_req;
  logic [8:0]  adv_count;

  logic [5:0]  g_day, s_day;
  logic [3:0]  g_mon, s_mon;
  logic [10:0] g_yr, s_yr;
  logic        g_upd, s_upd;
  logic        g_wrap, s_wrap;
  logic        g_err, s_err;
  logic        g_busy, s_busy;

  always #5 clk = ~clk;

  calendar_date_counter #(
    .cal_select(1'b0),
    .RESET_YEAR(11'd2018)
  ) u_greg (
    .clk(clk), .reset_n(reset_n),
    .day_tick(day_tick), .load(load),
    .ld_day(ld_day), .ld_month(ld_month),
    .ld_year(ld_year), .adv_req(adv_req),
    .adv_count(adv_count),
    .dayOfMonth(g_day), .month(g_mon),
    .year(g_yr), .date_upd(g_upd),
    .year_wrap(g_wrap), .load_err(g_err),
    .busy(g_busy)
  );

  calendar_date_counter #(
    .cal_select(1'b1),
    .RESET_YEAR(11'd2018)
  ) u_sym (
    .clk(clk), .reset_n(reset_n),
    .day_tick(day_tick), .load(load),
    .ld_day(ld_day), .ld_month(ld_month),
    .ld_year(ld_year), .adv_req(adv_req),
    .adv_count(adv_count),
    .dayOfMonth(s_day), .month(s_mon),
    .year(s_yr), .date_upd(s_upd),
    .year_wrap(s_wrap), .load_err(s_err),
    .busy(s_busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  int md[2], mm[2], my[2], mrem[2];
  bit mbusy[2], mupd[2], mwrap[2], merr[2];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic int days_in(int c, int m, int y);
    int greg[12] = '{31, 28, 31, 30, 31, 30,
                     31, 31, 30, 31, 30, 31};
    if (m < 1 || m > 12) return 0;
    if (c == 1) return (m % 3 == 2) ? 35 : 28;
    if (m == 2 && y % 4 == 0) return 29;
    return greg[m-1];
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 2; c++) begin
      md[c] = 1; mm[c] = 1; my[c] = 2018;
      mrem[c] = 0; mbusy[c] = 0;
      mupd[c] = 0; mwrap[c] = 0; merr[c] = 0;
    end
  endtask

  task automatic m_next_day(int c);
    mupd[c] = 1;
    if (md[c] < days_in(c, mm[c], my[c])) begin
      md[c]++;
    end else begin
      md[c] = 1;
      if (mm[c] == 12) begin
        mm[c] = 1;
        if (my[c] == 2047) begin
          my[c] = 0;
          mwrap[c] = 1;
        end else begin
          my[c]++;
        end
      end else begin
        mm[c]++;
      end
    end
  endtask

  task automatic m_clock(int c);
    int d, m, y;
    d = int'(ld_day);
    m = int'(ld_month);
    y = int'(ld_year);
    mupd[c] = 0; mwrap[c] = 0; merr[c] = 0;
    if (!mbusy[c]) begin
      if (load) begin
        if (d >= 1 && d <= days_in(c, m, y)) begin
          md[c] = d; mm[c] = m; my[c] = y;
          mupd[c] = 1;
        end else begin
          merr[c] = 1;
        end
      end else if (day_tick) begin
        m_next_day(c);
      end else if (adv_req && adv_count != 0) begin
        mbusy[c] = 1;
        mrem[c] = int'(adv_count);
      end
    end else begin
      merr[c] = load;
      if (day_tick && mrem[c] < 511) mrem[c]++;
      m_next_day(c);
      mrem[c]--;
      if (mrem[c] == 0) mbusy[c] = 0;
    end
  endtask

  task automatic check_all();
    chk("g_day", g_day, md[0]);
    chk("g_mon", g_mon, mm[0]);
    chk("g_yr", g_yr, my[0]);
    chk("g_upd", g_upd, mupd[0]);
    chk("g_wrap", g_wrap, mwrap[0]);
    chk("g_err", g_err, merr[0]);
    chk("g_busy", g_busy, mbusy[0]);
    chk("s_day", s_day, md[1]);
    chk("s_mon", s_mon, mm[1]);
    chk("s_yr", s_yr, my[1]);
    chk("s_upd", s_upd, mupd[1]);
    chk("s_wrap", s_wrap, mwrap[1]);
    chk("s_err", s_err, merr[1]);
    chk("s_busy", s_busy, mbusy[1]);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    m_clock(0);
    m_clock(1);
    check_all();
    day_tick = 1'b0;
    load     = 1'b0;
    adv_req  = 1'b0;
  endtask

  task automatic do_load(int d, int m, int y);
    ld_day   = 6'(d);
    ld_month = 4'(m);
    ld_year  = 11'(y);
    load     = 1'b1;
    cyc();
  endtask

  task automatic do_tick();
    day_tick = 1'b1;
    cyc();
  endtask

  task automatic run_adv(int cnt, int t1, int t2,
                         output int nb);
    int k;
    adv_req   = 1'b1;
    adv_count = 9'(cnt);
    cyc();
    nb = g_busy ? 1 : 0;
    k = 0;
    while (g_busy && k < 700) begin
      k++;
      if (k == t1 || k == t2) day_tick = 1'b1;
      cyc();
      if (g_busy) nb++;
    end
    chk("adv_bound", (k < 700) ? 1 : 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nb;
    reset_n   = 1'b0;
    day_tick  = 1'b0;
    load      = 1'b0;
    adv_req   = 1'b0;
    ld_day    = '0;
    ld_month  = '0;
    ld_year   = '0;
    adv_count = '0;
    m_reset();
    #12;
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
    cyc();

    do_load(28, 2, 2019);
    do_tick();
    chk("greg_mar1_mon", g_mon, 3);
    chk("greg_mar1_day", g_day, 1);
    do_load(28, 2, 2020);
    do_tick();
    chk("greg_leap_day", g_day, 29);
    do_tick();
    chk("greg_leap_mar", g_mon, 3);

    do_load(31, 12, 2047);
    do_tick();
    chk("wrap_yr", g_yr, 0);
    chk("wrap_pulse", g_wrap, 1);
    chk("wrap_upd", g_upd, 1);

    do_load(35, 2, 2018);
    chk("greg_rej_35", g_err, 1);
    chk("sym_acc_35", s_day, 35);
    do_tick();
    chk("sym_mar1_mon", s_mon, 3);
    do_load(28, 12, 2018);
    do_tick();
    chk("sym_ny_yr", s_yr, 2019);
    chk("sym_ny_mon", s_mon, 1);

    do_load(31, 4, 2019);
    chk("apr31_err", g_err, 1);
    day_tick = 1'b1;
    do_load(5, 5, 2019);
    chk("ld_prio_day", g_day, 5);
    chk("ld_prio_mon", g_mon, 5);

    do_load(1, 1, 2019);
    run_adv(365, -1, -1, nb);
    chk("adv365_busy", nb, 365);
    chk("adv365_yr", g_yr, 2020);
    chk("adv365_day", g_day, 1);

    do_load(1, 1, 2019);
    run_adv(365, 100, 200, nb);
    chk("adv367_busy", nb, 367);
    chk("adv367_day", g_day, 3);

    adv_req   = 1'b1;
    adv_count = 9'd0;
    cyc();
    chk("adv0_idle", g_busy, 0);

    do_load(1, 1, 2019);
    adv_req   = 1'b1;
    adv_count = 9'd300;
    cyc();
    repeat (10) cyc();
    reset_n = 1'b0;
    #1;
    m_reset();
    check_all();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) cyc();

    repeat (3000) begin
      load      = ($urandom_range(0, 7) == 0);
      day_tick  = ($urandom_range(0, 3) == 0);
      adv_req   = ($urandom_range(0, 15) == 0);
      adv_count = ($urandom_range(0, 7) == 0) ?
                  9'($urandom_range(0, 511)) :
                  9'($urandom_range(0, 20));
      ld_day    = 6'($urandom_range(0, 40));
      ld_month  = 4'($urandom_range(0, 15));
      ld_year   = ($urandom_range(0, 3) == 0) ?
                  11'd2047 :
                  11'($urandom_range(0, 2047));
      if ($urandom_range(0, 5) == 0) begin
        ld_month = 4'd12;
        ld_day   = ($urandom_range(0, 1) == 0) ?
                   6'd28 : 6'd31;
      end
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
